riscv_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the next-gen pipelined core: replaces the bare PC/InstrF pair

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 34 +++
 rtl/riscv_fetch_queue.sv | 74 +++++++
 tb/tb_riscv_fetch_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, constants and the fetch queue entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry in-order queue of fetch entries with synchronous clear and occupancy count
module fetch_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic push,
  input logic pop,
  input fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      if (rst)
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: imem request/response fetch front end with prefetch queue and redirect flush.
// Define FETCH_BYPASS_EN to let a kept response reach decode in the same cycle when the queue is empty.
module riscv_fetch_queue import riscv_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  input logic redirect_i,
  input logic [XLEN-1:0] redirect_pc_i,
  output logic imem_req_o,
  input logic imem_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input logic imem_rvalid_i,
  input logic [XLEN-1:0] imem_rdata_i,
  output logic instr_valid_o,
  input logic instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [OW-1:0] outst, drop, outst_nx;
  logic [CW-1:0] count;
  logic accept, keep, byp, push, pop, empty;
  fetch_entry_t din, head;
  // every in-flight request owns a queue slot, so a kept response always fits
  assign imem_req_o = !reset && !redirect_i && (int'(count) + int'(outst) < DEPTH) && (int'(outst) < MAX_OUTST);
  assign imem_addr_o = fetch_pc;
  assign accept = imem_req_o && imem_ready_i;
  assign keep = !reset && imem_rvalid_i && drop == '0 && !redirect_i;
  assign empty = count == '0;
  assign outst_nx = outst + OW'(accept) - OW'(imem_rvalid_i);
  assign din = '{pc: rsp_pc, instr: imem_rdata_i};
`ifdef FETCH_BYPASS_EN
  assign byp = keep && empty;
`else
  assign byp = 1'b0;
`endif
  assign instr_valid_o = !empty || byp;
  assign instr_o = byp ? imem_rdata_i : head.instr;
  assign pc_o = byp ? rsp_pc : head.pc;
  assign push = keep && !(byp && instr_ready_i);
  assign pop = !empty && instr_ready_i;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .clear(redirect_i),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outst <= '0;
      drop <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      rsp_pc <= redirect_pc_i;
      outst <= outst_nx;
      drop <= outst_nx;
    end else begin
      if (accept) fetch_pc <= fetch_pc + PC_STEP;
      if (keep) rsp_pc <= rsp_pc + PC_STEP;
      outst <= outst_nx;
      if (imem_rvalid_i && drop != '0) drop <= drop - OW'(1);
    end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: directed checks of the fetch queue against an in-order imem model returning ~addr
module tb_riscv_fetch_queue;
`ifdef FETCH_BYPASS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  typedef struct {
    logic req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc;
  } vec_t;
  logic clk = 0, reset = 1, redirect = 0, imem_ready = 1, instr_ready = 1, rsp_en = 1;
  logic [31:0] redirect_pc = 0;
  logic imem_req, imem_rvalid, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  int checks = 0, failures = 0, acc_cnt = 0, pend_n = 0;
  logic [31:0] exp_pc = 0, pend_head = 0, addr_s = 0;
  logic acc_s = 0, rv_s = 0;
  logic [31:0] pend [$];
  vec_t vt [6];

  always #5 clk = ~clk;

  riscv_fetch_queue dut (
    .clk(clk),
    .reset(reset),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req),
    .imem_ready_i(imem_ready),
    .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o(instr),
    .pc_o(pc)
  );

  assign imem_rvalid = rsp_en && pend_n > 0;
  assign imem_rdata = ~pend_head;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // sample the handshake mid-cycle, apply it to the in-order memory model at the edge
  always @(negedge clk) begin
    acc_s = imem_req && imem_ready;
    rv_s = imem_rvalid;
    addr_s = imem_addr;
    if (!reset && instr_valid && instr_ready) begin
      chk("order_pc", pc, exp_pc);
      chk("order_instr", instr, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      acc_cnt <= 0;
    end else begin
      if (rv_s) void'(pend.pop_front());
      if (acc_s) begin
        pend.push_back(addr_s);
        acc_cnt <= acc_cnt + 1;
      end
    end
    pend_n <= pend.size();
    pend_head <= pend.size() > 0 ? pend[0] : 32'h0;
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    redirect = 0;
    rsp_en = 1;
    imem_ready = 1;
    cyc(2);
    reset = 0;
    exp_pc = 0;
  endtask

  task automatic redir(logic [31:0] t);
    redirect = 1;
    redirect_pc = t;
    cyc();
    redirect = 0;
    exp_pc = t;
  endtask

  task automatic wait_valid(string name, logic [31:0] want);
    int n = 0;
    mid();
    while (!instr_valid && n < 20) begin
      @(posedge clk);
      #1;
      mid();
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 20), 1);
    chk({name, "_pc"}, pc, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls = 0;
    logic stalled = 0, have_prev = 0;
    logic [31:0] last_addr = 0, prev_acc = 0;
    for (int k = 0; k < 6; k++)
      vt[k] = '{1'b1, 32'(4 * k), (k >= 2 - B), 32'(4 * (k - 2 + B))};

    // reset state
    cyc(2);
    mid();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);

    // 1: streaming fetch, one instruction per cycle
    instr_ready = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("t1_req", imem_req, vt[k].req);
      chk("t1_addr", imem_addr, vt[k].addr);
      chk("t1_valid", instr_valid, vt[k].valid);
      if (vt[k].valid) begin
        chk("t1_pc", pc, vt[k].pc);
        chk("t1_instr", instr, ~vt[k].pc);
      end
      @(posedge clk);
      #1;
    end

    // 2: decode stalled, credits stop fetch at DEPTH
    instr_ready = 0;
    do_reset();
    cyc(10);
    mid();
    chk("t2_accepts", acc_cnt, 4);
    chk("t2_req_low", imem_req, 0);
    chk("t2_valid", instr_valid, 1);
    chk("t2_head_pc", pc, 0);
    cyc();
    instr_ready = 1;
    cyc(10);
    mid();
    chk("t2_resume", 32'(acc_cnt > 4), 1);
    cyc();

    // 3: two requests in flight then redirect, both responses dropped
    imem_ready = 0;
    cyc(4);
    rsp_en = 0;
    imem_ready = 1;
    redir(32'h10);
    cyc(4);
    mid();
    chk("t3_inflight", pend_n, 2);
    chk("t3_first_inflight", pend_head, 32'h10);
    chk("t3_req_held_off", imem_req, 0);
    cyc();
    redir(32'h200);
    rsp_en = 1;
    wait_valid("t3_first", 32'h200);

    // 4: redirect coincides with a response and a pop
    cyc(4);
    redirect = 1;
    redirect_pc = 32'h300;
    mid();
    chk("t4_rvalid_in", imem_rvalid, 1);
    chk("t4_valid_in", instr_valid, 32'(1 - B));
    chk("t4_req_in", imem_req, 0);
    @(posedge clk);
    #1;
    redirect = 0;
    exp_pc = 32'h300;
    mid();
    chk("t4_valid_after", instr_valid, 0);
    chk("t4_req_after", imem_req, 1);
    chk("t4_addr_after", imem_addr, 32'h300);
    @(posedge clk);
    #1;
    wait_valid("t4_first", 32'h300);

    // 5: imem_ready toggling, request held stable while stalled
    for (int i = 0; i < 16; i++) begin
      imem_ready = i[0];
      mid();
      if (stalled) begin
        chk("t5_req_held", imem_req, 1);
        chk("t5_addr_held", imem_addr, last_addr);
      end
      if (imem_req && imem_ready) begin
        if (have_prev) chk("t5_seq", imem_addr, prev_acc + 32'd4);
        prev_acc = imem_addr;
        have_prev = 1;
      end
      stalled = imem_req && !imem_ready;
      if (stalled) stalls++;
      last_addr = imem_addr;
      @(posedge clk);
      #1;
    end
    chk("t5_stalls_seen", 32'(stalls > 0), 1);

    // 6: PC wrap at the top of the address space
    imem_ready = 1;
    cyc(2);
    redir(32'hFFFF_FFF8);
    mid();
    chk("t6_addr_r1", imem_addr, 32'hFFFF_FFF8);
    chk("t6_req_r1", imem_req, 1);
    @(posedge clk);
    #1;
    mid();
    chk("t6_valid_r2", instr_valid, B);
    @(posedge clk);
    #1;
    mid();
    chk("t6_addr_wrap", imem_addr, 32'h0);
    chk("t6_valid_r3", instr_valid, 1);
    @(posedge clk);
    #1;
    cyc(8);
    mid();
    chk("t6_wrapped", 32'(exp_pc >= 32'h8 && exp_pc < 32'h40), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
